mem_arbiter_rr: RTL and testbench
=================================

# mem_arbiter_rr

N-port round-robin arbiter between the L1 caches (and any other line-granular masters) and the single cacheline memory adaptor. It generalises the two-port instruction/data arbiter to NUM_PORTS masters with parametrised line and address widths. It provides fair rotating priority, a registered grant held for a whole transaction, and back-to-back handover without an idle cycle. It sits between the cache array and the cacheline adaptor.

## Interface
- NUM_PORTS, 2: number of requesting masters (≥2); index 0 is the instruction cache by convention.
- LINE_W, 256: cacheline data width.
- ADDR_W, 32: address width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- port_read  in  [NUM_PORTS]  per-port read request, held until its resp.
- port_write  in  [NUM_PORTS]  per-port write request, held until its resp.
- port_addr  in  [NUM_PORTS] x ADDR_W  per-port line address.
- port_wdata  in  [NUM_PORTS] x LINE_W  per-port write line.
- port_rdata  out  [NUM_PORTS] x LINE_W  mem_rdata broadcast to every port.
- port_resp  out  [NUM_PORTS]  one-cycle completion, only to the granted port.
- mem_read / mem_write  out  1  request to adaptor.
- mem_address  out  ADDR_W  granted port address.
- mem_wdata  out  LINE_W  granted port write data.
- mem_rdata  in  LINE_W  adaptor read data.
- mem_resp  in  1  adaptor completion.
- grant_oh  out  [NUM_PORTS]  one-hot current owner; zero when idle.
- busy  out  1  state == BUSY.

## Operation
- States: IDLE, BUSY. Registers: state, grant index g, rotation pointer ptr ($clog2(NUM_PORTS) bits).
- A port requests when port_read | port_write.
- Winner: the first requesting port at or after ptr, modulo NUM_PORTS.
- IDLE:
  - If any port requests, the winner is registered into g and the state moves to BUSY.
  - Otherwise the state stays in IDLE.
- BUSY:
  - mem_write = port_write[g].
  - mem_read = port_read[g] & ~port_write[g]. Write wins if both are asserted.
  - mem_address = port_addr[g]; mem_wdata = port_wdata[g].
  - port_resp[g] = mem_resp, combinational.
- On mem_resp in BUSY:
  - ptr <= g+1, wrapping NUM_PORTS-1 → 0.
  - The next winner is chosen from requesters excluding g, starting at g+1.
  - If a winner exists, stay in BUSY with the new g. Otherwise go to IDLE.
- A granted port that drops its request without resp keeps the grant. mem_read and mem_write follow the port, i.e. go 0. No preemption.
- Defaults outside BUSY:
  - mem_read = mem_write = 0; port_resp = 0.
  - mem_address = port_addr[0]; mem_wdata = port_wdata[0].
- Reset values: state IDLE, g 0, ptr 0, grant_oh 0, busy 0, all resp/mem_read/mem_write 0.

## Timing
- Arbitration latency: request seen in IDLE at cycle t → mem_read/mem_write asserted at t+1.
- Handover: mem_resp at cycle t for port A → the next port's request is driven at t+1, with no idle cycle.
- port_resp is the same cycle as mem_resp. port_rdata is valid only in that cycle.
- Simultaneous requests from all ports: each port is served once per NUM_PORTS grants. Worst-case wait is NUM_PORTS-1 transactions.
- rst mid-transaction: next cycle IDLE, outputs at reset values. The adaptor is reset with the same rst.

## Configuration
- MEM_ARB_PERF_EN defined: adds per-port counters and outputs.
  - perf_grants [NUM_PORTS] x 32: increments on each port_resp.
  - perf_wait [NUM_PORTS] x 32: increments each cycle a port requests while not granted.
  - Both saturate at all-ones and clear on rst.
- Undefined: no counters, no perf ports; logic otherwise identical.

## Structure
- Package mem_arb_pkg holds:
  - state enum typedef (IDLE, BUSY).
  - PERF_CNT_W = 32.
- Sub-module rr_pick: combinational. Inputs: request vector, start pointer, exclude mask. Outputs: found, winner index.
  - Used for both the IDLE and the handover choice.

## Test plan
- Reset: hold rst 2 cycles with all ports requesting → grant_oh 0, mem_read 0. After release, grant port 0 at cycle +1.
- NUM_PORTS=4, all ports read:
  - Adaptor resps after 3 cycles each → grant order 0,1,2,3,0.
  - No IDLE gap between grants; busy constantly 1.
- Ports 1 and 3 request, ptr=2 → port 3 granted first, then port 1. mem_address tracks port_addr[3] then port_addr[1].
- Port 2 write 0xA5.. at addr 0x100 → mem_write 1, mem_read 0, mem_wdata matches. port_resp[2] pulses once; other resps stay 0.
- Only port 0 requests repeatedly → after each resp, IDLE for exactly one cycle, then re-grant.
- MEM_ARB_PERF_EN, ports 0 and 1 contend with 5-cycle transactions → perf_grants 1/1 after two transactions, perf_wait[1] = 6.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the N-port round-robin memory arbiter.
package mem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int unsigned PERF_CNT_W = 32;

   // Index width that stays legal for a single-port instance as well.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after start,
// wrapping modulo NUM_PORTS, skipping any port set in excl.
module rr_pick
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     start,
   input  logic [NUM_PORTS-1:0] excl,
   output logic                 found,
   output logic [IDX_W-1:0]     winner
);

   int unsigned      pos;
   logic [IDX_W-1:0] cand;

   always_comb begin
      found  = 1'b0;
      winner = '0;
      pos    = 0;
      cand   = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         pos = 32'(start) + i;
         if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
         cand = pos[IDX_W-1:0];
         if (!found && req[cand] && !excl[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin arbiter in front of the cacheline memory adaptor.
// Define MEM_ARB_PERF_EN to add per-port grant/wait performance counters.
module mem_arbiter_rr
   import mem_arb_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int LINE_W    = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             port_read,
   input  logic [NUM_PORTS-1:0]             port_write,
   input  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr,
   input  logic [NUM_PORTS-1:0][LINE_W-1:0] port_wdata,
   output logic [NUM_PORTS-1:0][LINE_W-1:0] port_rdata,
   output logic [NUM_PORTS-1:0]             port_resp,
   output logic                             mem_read,
   output logic                             mem_write,
   output logic [ADDR_W-1:0]                mem_address,
   output logic [LINE_W-1:0]                mem_wdata,
   input  logic [LINE_W-1:0]                mem_rdata,
   input  logic                             mem_resp,
   output logic [NUM_PORTS-1:0]             grant_oh,
   output logic                             busy
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [NUM_PORTS-1:0][PERF_CNT_W-1:0] perf_grants,
   output logic [NUM_PORTS-1:0][PERF_CNT_W-1:0] perf_wait
`endif
);

   localparam int               IDX_W = idx_w(NUM_PORTS);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_PORTS - 1);

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       g_q, g_d, ptr_q, ptr_d;
   logic [IDX_W-1:0]       g_next, pick_start, winner;
   logic [NUM_PORTS-1:0]   req, pick_excl;
   logic                   found;

   assign req    = port_read | port_write;
   assign g_next = (g_q == LAST) ? '0 : g_q + IDX_W'(1);

   // One picker serves both the idle choice (from ptr) and the handover
   // choice (from g+1, excluding the owner that is just completing).
   assign pick_start = (state_q == BUSY) ? g_next : ptr_q;

   always_comb begin
      pick_excl = '0;
      if (state_q == BUSY) pick_excl[g_q] = 1'b1;
   end

   rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_pick (
      .req    (req),
      .start  (pick_start),
      .excl   (pick_excl),
      .found  (found),
      .winner (winner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         g_q     <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         g_q     <= g_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      g_d     = g_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               g_d     = winner;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_resp) begin
               ptr_d = g_next;
               if (found) g_d = winner;
               else       state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_address = port_addr[0];
      mem_wdata   = port_wdata[0];
      port_resp   = '0;
      grant_oh    = '0;
      busy        = 1'b0;
      if (state_q == BUSY) begin
         busy           = 1'b1;
         grant_oh[g_q]  = 1'b1;
         port_resp[g_q] = mem_resp;
         mem_write      = port_write[g_q];
         mem_read       = port_read[g_q] & ~port_write[g_q];
         mem_address    = port_addr[g_q];
         mem_wdata      = port_wdata[g_q];
      end
   end

   assign port_rdata = {NUM_PORTS{mem_rdata}};

`ifdef MEM_ARB_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grants <= '0;
         perf_wait   <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (port_resp[i] && (perf_grants[i] != '1))
               perf_grants[i] <= perf_grants[i] + PERF_CNT_W'(1);
            if (req[i] && !grant_oh[i] && (perf_wait[i] != '1))
               perf_wait[i] <= perf_wait[i] + PERF_CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Self-checking bench for mem_arbiter_rr (4 ports) against a behavioural
// round-robin model; perf counters are checked when MEM_ARB_PERF_EN is set.
module tb_mem_arbiter_rr;

   localparam int N = 4;
   localparam int LW = 64;
   localparam int AW = 32;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N-1:0]          port_read, port_write;
   logic [N-1:0][AW-1:0]  port_addr;
   logic [N-1:0][LW-1:0]  port_wdata;
   logic [N-1:0][LW-1:0]  port_rdata;
   logic [N-1:0]          port_resp;
   logic                  mem_read, mem_write;
   logic [AW-1:0]         mem_address;
   logic [LW-1:0]         mem_wdata;
   logic [LW-1:0]         mem_rdata;
   logic                  mem_resp;
   logic [N-1:0]          grant_oh;
   logic                  busy;
`ifdef MEM_ARB_PERF_EN
   logic [N-1:0][31:0]    perf_grants, perf_wait;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: owner, busy flag, rotation pointer.
   bit m_busy;
   int m_g, m_ptr;

   mem_arbiter_rr #(
      .NUM_PORTS (N),
      .LINE_W    (LW),
      .ADDR_W    (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .port_read   (port_read),
      .port_write  (port_write),
      .port_addr   (port_addr),
      .port_wdata  (port_wdata),
      .port_rdata  (port_rdata),
      .port_resp   (port_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp),
      .grant_oh    (grant_oh),
      .busy        (busy)
`ifdef MEM_ARB_PERF_EN
      ,
      .perf_grants (perf_grants),
      .perf_wait   (perf_wait)
`endif
   );

   always #5 clk = ~clk;

   function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
      int p;
      for (int k = 0; k < N; k++) begin
         p = (start + k) % N;
         if (r[p] && p != excl) return p;
      end
      return -1;
   endfunction

   // Advance the model with the inputs the DUT sees at this edge, then step.
   task automatic tick();
      logic [N-1:0] r;
      int w;
      r = port_read | port_write;
      if (rst) begin
         m_busy = 0; m_g = 0; m_ptr = 0;
      end else if (!m_busy) begin
         w = pick(r, m_ptr, -1);
         if (w >= 0) begin m_busy = 1; m_g = w; end
      end else if (mem_resp) begin
         m_ptr = (m_g + 1) % N;
         w = pick(r, m_ptr, m_g);
         if (w >= 0) m_g = w;
         else m_busy = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      port_read  = '0;
      port_write = '0;
      mem_resp   = 1'b0;
      mem_rdata  = '0;
      for (int i = 0; i < N; i++) begin
         port_addr[i]  = $urandom;
         port_wdata[i] = {$urandom, $urandom};
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      port_read = '1;
      for (int c = 0; c < 2; c++) begin
         tick();
         n_checks++;
         if (grant_oh !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant_oh); end
         n_checks++;
         if (mem_read !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read: got %b want 0", mem_read); end
         n_checks++;
         if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle: got %b want 0", busy); end
      tick();
      n_checks++;
      if (grant_oh !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", grant_oh); end
      n_checks++;
      if (mem_read !== 1'b1) begin n_fail++; $display("FAIL reset_first_read: got %b want 1", mem_read); end
   endtask

   task automatic test_all_read();
      int order [5] = '{0, 1, 2, 3, 0};
      logic [N-1:0] exp_oh;
      do_reset();
      port_read = '1;
      tick();
      for (int t = 0; t < 5; t++) begin
         exp_oh = 4'(1 << order[t]);
         for (int c = 0; c < 3; c++) begin
            mem_resp = (c == 2);
            #1;
            n_checks++;
            if (grant_oh !== exp_oh || busy !== 1'b1) begin
               n_fail++; $display("FAIL all_read_grant t%0d c%0d: got %b busy %b want %b busy 1", t, c, grant_oh, busy, exp_oh);
            end
            n_checks++;
            if (mem_read !== 1'b1 || mem_address !== port_addr[order[t]]) begin
               n_fail++; $display("FAIL all_read_mem t%0d: got rd %b addr %h want rd 1 addr %h", t, mem_read, mem_address, port_addr[order[t]]);
            end
            if (c == 2) begin
               n_checks++;
               if (port_resp !== exp_oh) begin n_fail++; $display("FAIL all_read_resp t%0d: got %b want %b", t, port_resp, exp_oh); end
            end
            tick();
         end
      end
      mem_resp = 1'b0;
   endtask

   task automatic test_ptr_start();
      do_reset();
      port_read = 4'b0010;
      tick();
      n_checks++;
      if (grant_oh !== 4'b0010) begin n_fail++; $display("FAIL ptr_setup_grant: got %b want 0010", grant_oh); end
      mem_resp = 1'b1;
      #1;
      n_checks++;
      if (port_resp !== 4'b0010) begin n_fail++; $display("FAIL ptr_setup_resp: got %b want 0010", port_resp); end
      tick();
      port_read = '0;
      mem_resp  = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ptr_setup_idle: got %b want 0", busy); end
      port_read = 4'b1010;
      port_addr[1] = 32'h0000_1040;
      port_addr[3] = 32'h0000_3080;
      tick();
      n_checks++;
      if (grant_oh !== 4'b1000 || mem_address !== 32'h0000_3080) begin
         n_fail++; $display("FAIL ptr_first: got %b addr %h want 1000 addr 00003080", grant_oh, mem_address);
      end
      mem_resp = 1'b1;
      tick();
      port_read[3] = 1'b0;
      mem_resp = 1'b0;
      #1;
      n_checks++;
      if (grant_oh !== 4'b0010 || busy !== 1'b1 || mem_address !== 32'h0000_1040) begin
         n_fail++; $display("FAIL ptr_second: got %b busy %b addr %h want 0010 busy 1 addr 00001040", grant_oh, busy, mem_address);
      end
      mem_resp = 1'b1;
      tick();
      port_read = '0;
      mem_resp  = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL ptr_done_idle: got %b want 0", busy); end
   endtask

   task automatic test_write();
      logic [LW-1:0] pat;
      int pulses;
      pat = {8{8'hA5}};
      pulses = 0;
      do_reset();
      port_write    = 4'b0100;
      port_addr[2]  = 32'h0000_0100;
      port_wdata[2] = pat;
      tick();
      n_checks++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
         n_fail++; $display("FAIL write_dir: got wr %b rd %b want wr 1 rd 0", mem_write, mem_read);
      end
      n_checks++;
      if (mem_wdata !== pat || mem_address !== 32'h0000_0100 || grant_oh !== 4'b0100) begin
         n_fail++; $display("FAIL write_data: got %h addr %h oh %b want %h addr 00000100 oh 0100", mem_wdata, mem_address, grant_oh, pat);
      end
      for (int c = 0; c < 6; c++) begin
         mem_resp  = (c == 2);
         mem_rdata = {$urandom, $urandom};
         #1;
         if (port_resp[2] === 1'b1) pulses++;
         n_checks++;
         if ((port_resp & 4'b1011) !== 4'b0000) begin n_fail++; $display("FAIL write_other_resp c%0d: got %b want x0xx zero", c, port_resp); end
         if (c == 2) begin
            n_checks++;
            if (port_rdata[0] !== mem_rdata || port_rdata[3] !== mem_rdata) begin
               n_fail++; $display("FAIL write_rdata_bcast: got %h/%h want %h", port_rdata[0], port_rdata[3], mem_rdata);
            end
         end
         tick();
         if (c == 2) port_write = '0;
      end
      mem_resp = 1'b0;
      n_checks++;
      if (pulses !== 1) begin n_fail++; $display("FAIL write_resp_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_single_repeat();
      do_reset();
      port_read = 4'b0001;
      tick();
      for (int r = 0; r < 3; r++) begin
         mem_resp = 1'b0;
         #1;
         n_checks++;
         if (busy !== 1'b1 || grant_oh !== 4'b0001) begin n_fail++; $display("FAIL single_grant r%0d: got busy %b oh %b want 1 0001", r, busy, grant_oh); end
         tick();
         mem_resp = 1'b1;
         #1;
         n_checks++;
         if (port_resp !== 4'b0001) begin n_fail++; $display("FAIL single_resp r%0d: got %b want 0001", r, port_resp); end
         tick();
         mem_resp = 1'b0;
         #1;
         n_checks++;
         if (busy !== 1'b0 || grant_oh !== 4'b0000) begin n_fail++; $display("FAIL single_idle r%0d: got busy %b oh %b want 0 0000", r, busy, grant_oh); end
         tick();
      end
   endtask

   task automatic test_random();
      logic [N-1:0]  e_oh, e_resp;
      logic          e_rd, e_wr;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wdata;
      int            resp_port, k;
      do_reset();
      for (int cyc = 0; cyc < 500; cyc++) begin
         rst       = ($urandom % 64 == 0);
         mem_resp  = m_busy && ($urandom % 3 == 0);
         mem_rdata = {$urandom, $urandom};
         #1;
         e_oh    = m_busy ? 4'(1 << m_g) : 4'b0000;
         e_resp  = (m_busy && mem_resp) ? e_oh : 4'b0000;
         e_wr    = m_busy && port_write[m_g];
         e_rd    = m_busy && port_read[m_g] && !port_write[m_g];
         e_addr  = m_busy ? port_addr[m_g] : port_addr[0];
         e_wdata = m_busy ? port_wdata[m_g] : port_wdata[0];
         n_checks++;
         if (grant_oh !== e_oh || busy !== m_busy) begin
            n_fail++; $display("FAIL rand_grant cyc%0d: got %b busy %b want %b busy %b", cyc, grant_oh, busy, e_oh, m_busy);
         end
         n_checks++;
         if (port_resp !== e_resp) begin n_fail++; $display("FAIL rand_resp cyc%0d: got %b want %b", cyc, port_resp, e_resp); end
         n_checks++;
         if (mem_read !== e_rd || mem_write !== e_wr) begin
            n_fail++; $display("FAIL rand_rw cyc%0d: got rd %b wr %b want rd %b wr %b", cyc, mem_read, mem_write, e_rd, e_wr);
         end
         n_checks++;
         if (mem_address !== e_addr || mem_wdata !== e_wdata) begin
            n_fail++; $display("FAIL rand_bus cyc%0d: got %h/%h want %h/%h", cyc, mem_address, mem_wdata, e_addr, e_wdata);
         end
         k = $urandom % N;
         n_checks++;
         if (port_rdata[k] !== mem_rdata) begin n_fail++; $display("FAIL rand_rdata cyc%0d: got %h want %h", cyc, port_rdata[k], mem_rdata); end
         resp_port = (e_resp != 0) ? m_g : -1;
         tick();
         if (resp_port >= 0) begin
            port_read[resp_port]  = 1'b0;
            port_write[resp_port] = 1'b0;
         end
         for (int i = 0; i < N; i++) begin
            if (!(port_read[i] | port_write[i])) begin
               if ($urandom % 4 == 0) begin
                  k = $urandom % 3;
                  port_read[i]  = (k != 1);
                  port_write[i] = (k != 0);
                  port_addr[i]  = $urandom;
                  port_wdata[i] = {$urandom, $urandom};
               end
            end else if ($urandom % 32 == 0) begin
               port_read[i]  = 1'b0;
               port_write[i] = 1'b0;
            end
         end
      end
      rst = 1'b0;
      mem_resp = 1'b0;
   endtask

`ifdef MEM_ARB_PERF_EN
   task automatic test_perf();
      do_reset();
      port_read = 4'b0011;
      tick();
      for (int t = 0; t < 2; t++) begin
         for (int c = 0; c < 5; c++) begin
            mem_resp = (c == 4);
            tick();
         end
         port_read[t] = 1'b0;
      end
      mem_resp = 1'b0;
      #1;
      n_checks++;
      if (perf_grants[0] !== 32'd1 || perf_grants[1] !== 32'd1 || perf_grants[2] !== 32'd0) begin
         n_fail++; $display("FAIL perf_grants: got %0d/%0d/%0d want 1/1/0", perf_grants[0], perf_grants[1], perf_grants[2]);
      end
      n_checks++;
      if (perf_wait[1] !== 32'd6 || perf_wait[0] !== 32'd1) begin
         n_fail++; $display("FAIL perf_wait: got p1 %0d p0 %0d want 6 1", perf_wait[1], perf_wait[0]);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_all_read();
      test_ptr_start();
      test_write();
      test_single_repeat();
      test_random();
`ifdef MEM_ARB_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
